fetch_stage: RTL and testbench

Instruction fetch stage of the reduced RISC-V core. Holds the program counter, issues word reads to instruction memory over a req/ack handshake, and presents one instruction at a time, with its PC, to decode, where the immediate extender and control unit consume it. Accepts a taken-branch redirect (target = branch PC + sign-extended immediate) from downstream, and absorbs decode stalls with a one-entry skid buffer.

---
 rtl/fetch_stage.sv | 169 ++++++++++++++++
 tb/tb_fetch_stage.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch for the reduced RISC-V core. Owns the program counter,
//   issues word reads over a req/ack handshake, and hands one instruction at
//   a time (with its PC) to decode. A one-entry skid buffer absorbs a decode
//   stall that arrives while a read is completing. A taken branch redirects
//   the PC to branch_pc + ImmOp (word aligned).
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   imem_req/imem_addr  read request and word address to instruction memory
//   imem_ack/imem_rdata read completion and returned instruction word
//   instr/instr_pc      instruction presented to decode and its address
//   instr_valid         instr/instr_pc hold a live instruction
//   stall               decode cannot accept this cycle
//   PCsrc               taken-branch redirect
//   branch_pc/ImmOp     branch PC and sign-extended byte offset
// ---------------------------------------------------------------------------
module fetch_stage #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_ack,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   output logic                  instr_valid,
   input  logic                  stall,
   input  logic                  PCsrc,
   input  logic [ADDR_WIDTH-1:0] branch_pc,
   input  logic [DATA_WIDTH-1:0] ImmOp
);

   localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

   // FULL doubles as "skid buffer occupied"; no separate flag is kept.
   typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_FULL, ST_DRAIN} state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [ADDR_WIDTH-1:0] r_pc;
   logic [ADDR_WIDTH-1:0] r_drain_addr;   // address of the request abandoned by a redirect
   logic [DATA_WIDTH-1:0] r_instr;
   logic [ADDR_WIDTH-1:0] r_instr_pc;
   logic                  r_instr_valid;
   logic [DATA_WIDTH-1:0] r_skid;
   logic [ADDR_WIDTH-1:0] r_skid_pc;

   logic                  w_req;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic                  w_consume;
   logic                  w_slot_free;
   logic [ADDR_WIDTH-1:0] w_imm;
   logic [ADDR_WIDTH-1:0] w_target;

   assign w_consume   = r_instr_valid && !stall;
   assign w_slot_free = !r_instr_valid || w_consume;

   // ImmOp is already sign-extended; the signed cast keeps that when the
   // widths differ. Bits [1:0] are cleared to keep the target word aligned.
   assign w_imm    = ADDR_WIDTH'($signed(ImmOp));
   assign w_target = (branch_pc + w_imm) & ~ADDR_WIDTH'(3);

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   // NOTE: sequential blocks use non-blocking (<=) so every flop samples the
   // pre-edge values; blocking (=) here would create order-dependent races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next_state;
   end

   // -------------------------------------------------------------------------
   // Next state and memory-side outputs
   // -------------------------------------------------------------------------
   // NOTE: every variable gets a default before the case so no path leaves it
   // unassigned; a missing default would infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_req        = 1'b0;
      w_addr       = r_pc;
      case (r_state)
         ST_IDLE:  w_next_state = ST_FETCH;
         ST_FETCH: begin
            w_req = 1'b1;
            if (imem_ack) w_next_state = w_slot_free ? ST_FETCH : ST_FULL;
         end
         ST_FULL:  if (w_consume) w_next_state = ST_FETCH;
         ST_DRAIN: begin
            // Requests are never cancelled: hold the old address until acked.
            w_req  = 1'b1;
            w_addr = r_drain_addr;
            if (imem_ack) w_next_state = ST_FETCH;
         end
         default:  w_next_state = ST_IDLE;
      endcase
      // Redirect overrides; an un-acked request must still be drained.
      if (PCsrc) begin
         w_next_state = ((r_state == ST_FETCH || r_state == ST_DRAIN) && !imem_ack)
                        ? ST_DRAIN : ST_FETCH;
      end
   end

   assign imem_req  = w_req;
   assign imem_addr = w_addr;

   // -------------------------------------------------------------------------
   // PC and output slot
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc          <= RESET_PC;
         r_drain_addr  <= RESET_PC;
         r_instr       <= NOP;
         r_instr_pc    <= '0;
         r_instr_valid <= 1'b0;
      end else if (PCsrc) begin
         // Any word acked this cycle is dropped along with the slot and skid.
         r_pc          <= w_target;
         r_instr_valid <= 1'b0;
         if (r_state == ST_FETCH) r_drain_addr <= r_pc;
      end else begin
         if (w_consume) r_instr_valid <= 1'b0;
         case (r_state)
            ST_FETCH: begin
               if (imem_ack) begin
                  r_pc <= r_pc + ADDR_WIDTH'(4);
                  if (w_slot_free) begin
                     r_instr       <= imem_rdata;
                     r_instr_pc    <= r_pc;
                     r_instr_valid <= 1'b1;
                  end
               end
            end
            ST_FULL: begin
               if (w_consume) begin
                  r_instr       <= r_skid;
                  r_instr_pc    <= r_skid_pc;
                  r_instr_valid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Skid buffer payload
   // -------------------------------------------------------------------------
   // NOTE: the payload is left without reset; it is only read in FULL, and
   // FULL is only entered on the same edge that writes it.
   always_ff @(posedge clk) begin
      if (r_state == ST_FETCH && imem_ack && !w_slot_free && !PCsrc) begin
         r_skid    <= imem_rdata;
         r_skid_pc <= r_pc;
      end
   end

   assign instr       = r_instr;
   assign instr_pc    = r_instr_pc;
   assign instr_valid = r_instr_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage. A memory model with programmable wait
//   states returns addr + 0x100. A monitor keeps a stream-level model
//   (expected next consumed PC, expected next fetch address, words held in
//   the stage) and checks the DUT every cycle; directed sequences pin exact
//   cycle timing with hand-computed values.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h0;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        stall;
   logic        PCsrc;
   logic [31:0] branch_pc;
   logic [31:0] ImmOp;

   always #5 clk = ~clk;

   fetch_stage #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(32),
      .RESET_PC  (RESET_PC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .instr      (instr),
      .instr_pc   (instr_pc),
      .instr_valid(instr_valid),
      .stall      (stall),
      .PCsrc      (PCsrc),
      .branch_pc  (branch_pc),
      .ImmOp      (ImmOp)
   );

   // ---------------- memory model ----------------
   int       wait_states;
   logic [3:0] mem_cnt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    mem_cnt <= '0;
      else if (imem_req && !imem_ack) mem_cnt <= mem_cnt + 4'd1;
      else                           mem_cnt <= '0;
   end

   assign imem_ack   = imem_req && (mem_cnt == 4'(wait_states));
   assign imem_rdata = imem_addr + 32'h100;

   // ---------------- checking ----------------
   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
   endtask

   // Stream-level model state.
   logic [31:0] m_exp_pc;     // PC of the next instruction decode must receive
   logic [31:0] m_exp_fetch;  // address of the next fetch whose data is kept
   int          m_occ;        // words fetched and kept but not yet consumed
   bit          m_discard;    // an outstanding request's data must be dropped
   logic [31:0] m_tgt;
   bit          p_live, p_req, p_ack, p_valid, p_stall, p_pcsrc;
   logic [31:0] p_addr, p_instr, p_instr_pc, p_target;

   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_req", {31'b0, imem_req}, 32'd0);
         check("rst_valid", {31'b0, instr_valid}, 32'd0);
         m_exp_pc    = RESET_PC;
         m_exp_fetch = RESET_PC;
         m_occ       = 0;
         m_discard   = 1'b0;
         p_live      = 1'b0;
      end else begin
         check("occ_valid", {31'b0, instr_valid}, {31'b0, m_occ != 0});
         if (m_occ >= 2) check("full_no_req", {31'b0, imem_req}, 32'd0);
         if (imem_req) check("addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
         if (p_live && p_req && !p_ack) begin
            check("hold_req", {31'b0, imem_req}, 32'd1);
            check("hold_addr", imem_addr, p_addr);
         end
         if (p_live && p_valid && p_stall && !p_pcsrc) begin
            check("stall_valid", {31'b0, instr_valid}, 32'd1);
            check("stall_instr", instr, p_instr);
            check("stall_pc", instr_pc, p_instr_pc);
         end
         if (p_live && p_pcsrc) begin
            check("redir_valid", {31'b0, instr_valid}, 32'd0);
            if (!p_req || p_ack) begin
               check("redir_req", {31'b0, imem_req}, 32'd1);
               check("redir_addr", imem_addr, p_target);
            end
         end
         if (instr_valid && !stall) begin
            check("cons_pc", instr_pc, m_exp_pc);
            check("cons_instr", instr, m_exp_pc + 32'h100);
            m_exp_pc = m_exp_pc + 32'd4;
            m_occ--;
         end
         if (imem_req && imem_ack) begin
            if (m_discard) m_discard = 1'b0;
            else begin
               check("fetch_addr", imem_addr, m_exp_fetch);
               m_exp_fetch = m_exp_fetch + 32'd4;
               m_occ++;
            end
         end
         m_tgt = (branch_pc + ImmOp) & ~32'h3;
         if (PCsrc) begin
            m_exp_pc    = m_tgt;
            m_exp_fetch = m_tgt;
            m_occ       = 0;
            m_discard   = imem_req && !imem_ack;
         end
         p_live     = 1'b1;
         p_req      = imem_req;
         p_ack      = imem_ack;
         p_addr     = imem_addr;
         p_valid    = instr_valid;
         p_stall    = stall;
         p_pcsrc    = PCsrc;
         p_instr    = instr;
         p_instr_pc = instr_pc;
         p_target   = m_tgt;
      end
   end

   // ---------------- stimulus ----------------
   // Drives and directed checks happen 2 time units after the rising edge.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic reset_with_waits(input int ws);
      rst_n       = 1'b0;
      wait_states = ws;
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n       = 1'b0;
      stall       = 1'b0;
      PCsrc       = 1'b0;
      branch_pc   = '0;
      ImmOp       = '0;
      wait_states = 0;
      step();
      step();

      // Reset values
      check("reset_req", {31'b0, imem_req}, 32'd0);
      check("reset_addr", imem_addr, 32'h0);
      check("reset_instr", instr, NOP);
      check("reset_instr_pc", instr_pc, 32'h0);
      check("reset_valid", {31'b0, instr_valid}, 32'd0);

      // Zero-wait start-up: IDLE, then one instruction per cycle
      rst_n = 1'b1;
      check("idle_req", {31'b0, imem_req}, 32'd0);
      step();
      check("e1_req", {31'b0, imem_req}, 32'd1);
      check("e1_addr", imem_addr, 32'h0);
      check("e1_valid", {31'b0, instr_valid}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         step();
         check("zw_valid", {31'b0, instr_valid}, 32'd1);
         check("zw_instr", instr, 32'h100 + 32'(4 * k));
         check("zw_pc", instr_pc, 32'(4 * k));
         check("zw_addr", imem_addr, 32'(4 * (k + 1)));
      end

      // Stall for 4 cycles while 0x10C is presented; 0x110 lands in the skid
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check("full_req", {31'b0, imem_req}, 32'd0);
         check("full_instr", instr, 32'h10C);
         check("full_valid", {31'b0, instr_valid}, 32'd1);
      end
      step();
      stall = 1'b0;
      check("release_req", {31'b0, imem_req}, 32'd0);
      check("release_instr", instr, 32'h10C);
      step();
      check("skid_out_instr", instr, 32'h110);
      check("skid_out_pc", instr_pc, 32'h10);
      check("skid_out_addr", imem_addr, 32'h14);
      check("skid_out_req", {31'b0, imem_req}, 32'd1);
      step();
      check("after_skid_instr", instr, 32'h114);

      // Zero-wait redirect: 0x20 + (-16) = 0x10; same-cycle acked word dropped
      check("pre_redir_ack", {31'b0, imem_ack}, 32'd1);
      PCsrc     = 1'b1;
      branch_pc = 32'h20;
      ImmOp     = 32'hFFFF_FFF0;
      step();
      PCsrc = 1'b0;
      check("redir_valid0", {31'b0, instr_valid}, 32'd0);
      check("redir_addr0", imem_addr, 32'h10);
      check("redir_req0", {31'b0, imem_req}, 32'd1);
      step();
      check("redir_first_valid", {31'b0, instr_valid}, 32'd1);
      check("redir_first_pc", instr_pc, 32'h10);
      check("redir_first_instr", instr, 32'h110);

      // Two wait states: one word every 3 cycles
      reset_with_waits(2);
      begin
         int cyc;
         cyc = 0;
         while (!instr_valid && cyc < 20) begin
            step();
            cyc++;
         end
         check("w2_first_valid", {31'b0, instr_valid}, 32'd1);
         check("w2_latency", 32'(cyc), 32'd4);
      end
      for (int k = 0; k < 10; k++) begin
         check("w2_valid", {31'b0, instr_valid}, {31'b0, (k % 3) == 0});
         if ((k % 3) == 0) check("w2_instr", instr, 32'h100 + 32'(4 * (k / 3)));
         if (k < 9) step();
      end

      // Asynchronous reset in the middle of a pending request
      check("pre_arst_req", {31'b0, imem_req}, 32'd1);
      check("pre_arst_valid", {31'b0, instr_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("arst_req", {31'b0, imem_req}, 32'd0);
      check("arst_valid", {31'b0, instr_valid}, 32'd0);
      check("arst_addr", imem_addr, RESET_PC);
      step();
      rst_n = 1'b1;
      step();
      check("restart_req", {31'b0, imem_req}, 32'd1);
      check("restart_addr", imem_addr, RESET_PC);
      begin
         int cyc;
         cyc = 0;
         while (!instr_valid && cyc < 20) begin
            step();
            cyc++;
         end
         check("restart_valid", {31'b0, instr_valid}, 32'd1);
         check("restart_instr", instr, 32'h100);
         check("restart_pc", instr_pc, RESET_PC);
      end

      // Redirect while a 3-wait request to 0x40 is outstanding
      reset_with_waits(3);
      begin
         int cyc;
         cyc = 0;
         while (!(imem_req && imem_addr == 32'h40) && cyc < 200) begin
            step();
            cyc++;
         end
         check("w3_reach_0x40", imem_addr, 32'h40);
      end
      check("w3_outstanding", {31'b0, imem_ack}, 32'd0);
      PCsrc     = 1'b1;
      branch_pc = 32'h100;
      ImmOp     = 32'h26;          // 0x126 aligns down to 0x124
      step();
      PCsrc = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check("drain_req", {31'b0, imem_req}, 32'd1);
         check("drain_addr", imem_addr, 32'h40);
         check("drain_valid", {31'b0, instr_valid}, 32'd0);
         step();
      end
      check("tgt_req", {31'b0, imem_req}, 32'd1);
      check("tgt_addr", imem_addr, 32'h124);
      for (int k = 0; k < 4; k++) begin
         check("tgt_wait_valid", {31'b0, instr_valid}, 32'd0);
         step();
      end
      check("tgt_valid", {31'b0, instr_valid}, 32'd1);
      check("tgt_pc", instr_pc, 32'h124);
      check("tgt_instr", instr, 32'h224);

      step();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
      $fatal(1);
   end

endmodule
